// File: rtl/apex7_pkg.sv
// +--------------------------------------------------------------------+
// | apex7_pkg: shared types, select-code constants and helpers for the |
// | apex7 channel-select encoder.                      Revision: 1.0   |
// +--------------------------------------------------------------------+
`default_nettype none

package apex7_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DRIVE    = 2'd1,
    WAIT_ACK = 2'd2,
    GAP      = 2'd3
  } state_e;

  localparam logic [2:0] SEL_BASE = 3'd2;
  localparam logic [2:0] SEL_NONE = 3'b000;
  localparam int         MAX_CH   = 6;

  // Codes 000 and 001 produce no decoder strobe, so channels start at 010.
  function automatic logic [2:0] ch2code(input logic [2:0] idx);
    return SEL_BASE + idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/apex7_rr_arb.sv
// +--------------------------------------------------------------------+
// | apex7_rr_arb: combinational round-robin pick of the first set      |
// | request at or after ptr, wrapping modulo NUM_CH.   Revision: 1.0   |
// +--------------------------------------------------------------------+
`default_nettype none

module apex7_rr_arb #(
  parameter int NUM_CH = 6
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [2:0]        ptr_i,
  output logic              any_o,
  output logic [2:0]        idx_o
);

  int         cand;
  logic [2:0] cand_idx;

  // Scan from the farthest offset down so the nearest set request wins last.
  always_comb begin
    any_o    = 1'b0;
    idx_o    = 3'd0;
    cand     = 0;
    cand_idx = 3'd0;
    for (int off = NUM_CH - 1; off >= 0; off--) begin
      cand     = (int'(ptr_i) + off) % NUM_CH;
      cand_idx = 3'(cand);
      if (req_i[cand_idx]) begin
        any_o = 1'b1;
        idx_o = cand_idx;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/apex7_sel_encoder.sv
// +--------------------------------------------------------------------+
// | apex7_sel_encoder: arbitrates channel requests, drives the 3-bit   |
// | select code/valid and retires on the strobe echo.  Revision: 1.0   |
// +--------------------------------------------------------------------+
`default_nettype none

module apex7_sel_encoder
  import apex7_pkg::*;
#(
  parameter int NUM_CH   = 6,
  parameter int HOLD_CYC = 2,
  parameter int TIMEOUT  = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] req_i,
  input  logic [NUM_CH-1:0] strobe_ack_i,
  output logic [NUM_CH-1:0] gnt_o,
  output logic [2:0]        sel_code_o,
  output logic              sel_valid_o,
  output logic              busy_o,
  output logic              err_timeout_o,
  output logic              err_proto_o
);

  localparam int CNT_MAX = (HOLD_CYC > TIMEOUT) ? HOLD_CYC : TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT - 1);

  state_e            state_q;
  logic [2:0]        idx_q;
  logic [2:0]        ptr_q;
  logic [2:0]        code_q;
  logic              valid_q;
  logic              ack_seen_q;
  logic              err_to_q;
  logic              err_proto_q;
  logic [NUM_CH-1:0] gnt_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              arb_any;
  logic [2:0]        arb_idx;
  logic [2:0]        ptr_d;
  logic [NUM_CH-1:0] idx_oh;
  logic              ack_hit;
  logic              ack_stray;

  apex7_rr_arb #(
    .NUM_CH (NUM_CH)
  ) u_arb (
    .req_i (req_i),
    .ptr_i (ptr_q),
    .any_o (arb_any),
    .idx_o (arb_idx)
  );

  assign ptr_d     = (arb_idx == 3'(NUM_CH - 1)) ? 3'd0 : arb_idx + 3'd1;
  assign idx_oh    = NUM_CH'(1) << idx_q;
  assign ack_hit   = |(strobe_ack_i & idx_oh);
  assign ack_stray = |(strobe_ack_i & ~idx_oh);

  // cnt_q counts DRIVE cycles, then is reused as the WAIT_ACK timer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= 3'd0;
      ptr_q       <= 3'd0;
      code_q      <= SEL_NONE;
      valid_q     <= 1'b0;
      ack_seen_q  <= 1'b0;
      err_to_q    <= 1'b0;
      err_proto_q <= 1'b0;
      gnt_q       <= '0;
      cnt_q       <= '0;
    end else begin
      gnt_q    <= '0;
      err_to_q <= 1'b0;
      if (state_q != IDLE && ack_stray) begin
        err_proto_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (arb_any) begin
            idx_q      <= arb_idx;
            ptr_q      <= ptr_d;
            code_q     <= ch2code(arb_idx);
            valid_q    <= 1'b1;
            ack_seen_q <= 1'b0;
            cnt_q      <= '0;
            state_q    <= DRIVE;
          end
        end
        DRIVE: begin
          if (ack_hit) begin
            ack_seen_q <= 1'b1;
          end
          if (cnt_q == HOLD_LAST) begin
            cnt_q   <= '0;
            state_q <= WAIT_ACK;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        WAIT_ACK: begin
          // An ack arriving on the final timer cycle still counts as success.
          if (ack_seen_q || ack_hit) begin
            gnt_q   <= idx_oh;
            valid_q <= 1'b0;
            code_q  <= SEL_NONE;
            state_q <= GAP;
          end else if (cnt_q == TO_LAST) begin
            err_to_q <= 1'b1;
            valid_q  <= 1'b0;
            code_q   <= SEL_NONE;
            state_q  <= GAP;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        GAP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign gnt_o         = gnt_q;
  assign sel_code_o    = code_q;
  assign sel_valid_o   = valid_q;
  assign busy_o        = (state_q != IDLE);
  assign err_timeout_o = err_to_q;
  assign err_proto_o   = err_proto_q;

endmodule

`default_nettype wire

// File: tb/tb_apex7_sel_encoder.sv
// +--------------------------------------------------------------------+
// | tb_apex7_sel_encoder: directed and random stimulus against a       |
// | transfer-phase reference model.                    Revision: 1.0   |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_apex7_sel_encoder;

  localparam int NUM_CH = 6;
  localparam int HOLD   = 2;
  localparam int TMO    = 15;

  logic              clk   = 1'b0;
  logic              rst_n = 1'b0;
  logic [NUM_CH-1:0] req   = '0;
  logic [NUM_CH-1:0] ack   = '0;
  logic [NUM_CH-1:0] gnt;
  logic [2:0]        sel_code;
  logic              sel_valid;
  logic              busy;
  logic              err_to;
  logic              err_proto;

  int total = 0;
  int bad   = 0;

  // Model: phase 0 idle, 1 transfer (k = cycle number with valid), 2 gap.
  int m_phase, m_k, m_ch, m_ptr, m_gnt;
  bit m_acked, m_proto, m_to;

  logic [NUM_CH-1:0] pend;
  logic [NUM_CH-1:0] stray_mask;
  int ack_at, stray_k;
  bit clr_on_gnt, rnd_ack;

  always #5 clk = ~clk;

  apex7_sel_encoder #(
    .NUM_CH   (NUM_CH),
    .HOLD_CYC (HOLD),
    .TIMEOUT  (TMO)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_i         (req),
    .strobe_ack_i  (ack),
    .gnt_o         (gnt),
    .sel_code_o    (sel_code),
    .sel_valid_o   (sel_valid),
    .busy_o        (busy),
    .err_timeout_o (err_to),
    .err_proto_o   (err_proto)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_k = 0; m_ch = 0; m_ptr = 0; m_gnt = -1;
    m_acked = 0; m_proto = 0; m_to = 0;
  endtask

  task automatic model_step(input logic [NUM_CH-1:0] r, input logic [NUM_CH-1:0] a);
    bit np;
    bit found;
    int c;
    np = m_proto;
    if (m_phase != 0)
      for (int b = 0; b < NUM_CH; b++)
        if (a[b] && b != m_ch) np = 1;
    m_gnt = -1;
    m_to  = 0;
    case (m_phase)
      0: if (r != 0) begin
        found = 0;
        for (int off = 0; off < NUM_CH; off++) begin
          c = (m_ptr + off) % NUM_CH;
          if (!found && r[c]) begin found = 1; m_ch = c; end
        end
        m_ptr = (m_ch + 1) % NUM_CH;
        m_phase = 1; m_k = 1; m_acked = 0;
      end
      1: begin
        if (a[m_ch]) m_acked = 1;
        if (m_k > HOLD && m_acked) begin m_gnt = m_ch; m_phase = 2; end
        else if (m_k == HOLD + TMO) begin m_to = 1; m_phase = 2; end
        else m_k++;
      end
      default: m_phase = 0;
    endcase
    m_proto = np;
  endtask

  task automatic check_all();
    logic [NUM_CH-1:0] eg;
    eg = '0;
    if (m_gnt >= 0) eg[m_gnt] = 1'b1;
    chk("gnt", 32'(gnt), 32'(eg));
    chk("sel_valid", 32'(sel_valid), 32'(m_phase == 1));
    chk("sel_code", 32'(sel_code), (m_phase == 1) ? 32'(m_ch + 2) : 32'd0);
    chk("busy", 32'(busy), 32'(m_phase != 0));
    chk("err_timeout", 32'(err_to), 32'(m_to));
    chk("err_proto", 32'(err_proto), 32'(m_proto));
  endtask

  task automatic tick();
    logic [NUM_CH-1:0] a;
    a = '0;
    if (m_phase == 1 && (ack_at == 0 || m_k == ack_at)) a[m_ch] = 1'b1;
    if (m_phase == 1 && m_k == stray_k) a = a | stray_mask;
    req = pend;
    ack = a;
    model_step(pend, a);
    if (rnd_ack && m_phase == 1 && m_k == 1) ack_at = $urandom_range(1, HOLD + TMO + 3);
    @(negedge clk);
    check_all();
    if (clr_on_gnt && m_gnt >= 0) pend[m_gnt] = 1'b0;
  endtask

  function automatic int oh2ch(input logic [NUM_CH-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < NUM_CH; i++) if (v[i]) r = i;
    return r;
  endfunction

  initial begin
    int gstep, n, first_len, to_cnt, gcnt, guard;
    bit revalid, prev_v;
    int got[4];
    int codes[4];

    model_reset();
    pend = '0; stray_mask = '0; ack_at = 99; stray_k = -1;
    clr_on_gnt = 1; rnd_ack = 0;

    // Reset state
    repeat (2) @(negedge clk);
    check_all();
    rst_n = 1'b1;

    // Single request, ack one cycle after valid
    pend = 6'b000001; ack_at = 2; gstep = -1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (gnt[0] && gstep < 0) gstep = i;
    end
    chk("single_gnt_cycle", 32'(gstep), 32'd4);

    // Round robin with requests held
    pend = 6'b101010; clr_on_gnt = 0; n = 0; prev_v = 0;
    for (int i = 0; i < 4; i++) begin got[i] = -1; codes[i] = -1; end
    for (int i = 0; i < 60 && n < 4; i++) begin
      tick();
      if (sel_valid && !prev_v && n < 4) codes[n] = int'(sel_code);
      prev_v = sel_valid;
      if (gnt != 0) begin got[n] = oh2ch(gnt); n++; end
    end
    chk("rr_grant0", 32'(got[0]), 32'd1);
    chk("rr_grant1", 32'(got[1]), 32'd3);
    chk("rr_grant2", 32'(got[2]), 32'd5);
    chk("rr_grant3", 32'(got[3]), 32'd1);
    chk("rr_code0", 32'(codes[0]), 32'b011);
    chk("rr_code1", 32'(codes[1]), 32'b101);
    chk("rr_code2", 32'(codes[2]), 32'b111);
    chk("rr_code3", 32'(codes[3]), 32'b011);
    pend = '0; clr_on_gnt = 1;
    repeat (25) tick();

    // Timeout on ch4, then re-arbitration
    pend = 6'b010000; ack_at = 99;
    first_len = 0; to_cnt = 0; gcnt = 0; revalid = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (to_cnt == 0 && sel_valid && sel_code == 3'b110) first_len++;
      if (err_to) to_cnt++;
      else if (to_cnt > 0 && sel_valid && sel_code == 3'b110) revalid = 1;
      if (gnt != 0) gcnt++;
    end
    chk("to_valid_len", 32'(first_len), 32'(HOLD + TMO));
    chk("to_pulses", 32'(to_cnt), 32'd1);
    chk("to_no_gnt", 32'(gcnt), 32'd0);
    chk("to_rearb", 32'(revalid), 32'd1);
    pend = '0; ack_at = 0;
    repeat (30) tick();

    // Early ack in the first DRIVE cycle
    pend = 6'b000100; ack_at = 1; gstep = -1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (gnt[2] && gstep < 0) gstep = i;
    end
    chk("early_gnt_cycle", 32'(gstep), 32'd4);

    // Random requests and ack delays
    rnd_ack = 1; ack_at = 3;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) pend = pend | NUM_CH'($urandom_range(0, 63));
      tick();
    end
    guard = 0;
    while (!(pend == 0 && m_phase == 0) && guard < 400) begin
      tick();
      guard++;
    end
    chk("random_drained", 32'(pend == 0 && m_phase == 0), 32'd1);
    rnd_ack = 0;
    repeat (2) tick();

    // Protocol error: stray ack on ch3 while ch0 active
    pend = 6'b000001; ack_at = 2; stray_k = 1; stray_mask = 6'b001000; gcnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (gnt[0]) gcnt++;
    end
    chk("proto_flag", 32'(err_proto), 32'd1);
    chk("proto_ch0_done", 32'(gcnt), 32'd1);
    stray_k = -1;
    repeat (5) tick();
    chk("proto_sticky", 32'(err_proto), 32'd1);

    // Reset in the middle of WAIT_ACK on ch2 (leaves pointer at 3)
    pend = 6'b000100; ack_at = 99; guard = 0;
    while (!(m_phase == 1 && m_k == HOLD + 2) && guard < 30) begin
      tick();
      guard++;
    end
    chk("reached_wait", 32'(m_phase == 1 && m_k == HOLD + 2), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(sel_valid), 32'd0);
    chk("arst_code", 32'(sel_code), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_gnt", 32'(gnt), 32'd0);
    chk("arst_err_to", 32'(err_to), 32'd0);
    chk("arst_err_proto", 32'(err_proto), 32'd0);
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    rst_n = 1'b1;
    pend = 6'b111111; ack_at = 2; guard = 0;
    while (!sel_valid && guard < 5) begin
      tick();
      guard++;
    end
    chk("post_reset_ch0", 32'(sel_code), 32'b010);
    repeat (60) tick();
    chk("post_reset_all_done", 32'(pend), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
